serial_word_assembler: RTL and testbench



---
 rtl/serial_pkg.sv | 13 +
 rtl/sipo_shift_reg.sv | 32 +++
 rtl/serial_word_assembler.sv | 114 +++++++++++
 tb/tb_serial_word_assembler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and helpers for the serial word assembler
package serial_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } asm_state_t;

  function automatic int count_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// rtl/sipo_shift_reg.sv - serial-in parallel-out assembly register
module sipo_shift_reg #(
  parameter int DATA_WIDTH = 32,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  shift_en,
  input  logic                  clear,
  input  logic                  bit_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] word_next
);

  // word_next is exposed so a completing bit can reach the output slot in the same edge
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign word_next = {word[DATA_WIDTH-2:0], bit_in};
    end else begin : g_lsb_first
      assign word_next = {bit_in, word[DATA_WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      word <= '0;
    end else if (shift_en) begin
      word <= word_next;
    end
  end

endmodule

// File: rtl/serial_word_assembler.sv
// rtl/serial_word_assembler.sv - assembles a handshaked bit stream into registered words
module serial_word_assembler
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                din,
  input  logic                                din_valid,
  output logic                                din_ready,
  input  logic                                flush,
  output logic [DATA_WIDTH-1:0]               dout,
  output logic                                dout_valid,
  input  logic                                dout_ready,
  output logic [count_width(DATA_WIDTH)-1:0]  bit_count
);

  localparam int CW = count_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);

  asm_state_t state, state_next;

  logic                  shift_en;
  logic                  asm_clear;
  logic                  complete;
  logic                  slot_free;
  logic                  consume;
  logic [DATA_WIDTH-1:0] asm_word;
  logic [DATA_WIDTH-1:0] asm_word_next;

  always_comb begin
    consume   = dout_valid && dout_ready;
    slot_free = !dout_valid || dout_ready;
    // a bit presented alongside flush is dropped, never counted
    shift_en  = din_valid && din_ready && !flush;
    asm_clear = flush && (state == FILL);
    complete  = shift_en && (bit_count == LAST);
  end

  sipo_shift_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sipo (
    .clk      (clk),
    .resetn   (resetn),
    .shift_en (shift_en),
    .clear    (asm_clear),
    .bit_in   (din),
    .word     (asm_word),
    .word_next(asm_word_next)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (complete && !slot_free) state_next = HOLD;
      HOLD:    if (consume) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    din_ready = (state == FILL);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bit_count  <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (asm_clear) begin
            bit_count <= '0;
          end else if (shift_en) begin
            if (complete) begin
              bit_count <= slot_free ? '0 : FULL;
            end else begin
              bit_count <= bit_count + 1'b1;
            end
          end
        end
        HOLD: begin
          if (consume) bit_count <= '0;
        end
        default: bit_count <= '0;
      endcase

      // in HOLD the completed word is parked in the assembly register
      if ((state == FILL) && complete && slot_free) begin
        dout       <= asm_word_next;
        dout_valid <= 1'b1;
      end else if ((state == HOLD) && consume) begin
        dout       <= asm_word;
        dout_valid <= 1'b1;
      end else if (consume) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_assembler.sv
// tb/tb_serial_word_assembler.sv - scoreboard bench for serial_word_assembler at width 8
module tb_serial_word_assembler;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          resetn;
  logic          din;
  logic          din_valid;
  logic          flush;
  logic          dout_ready;

  logic          m_din_ready, l_din_ready;
  logic [W-1:0]  m_dout, l_dout;
  logic          m_dout_valid, l_dout_valid;
  logic [CW-1:0] m_bit_count, l_bit_count;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [W-1:0]  exp_m[$];
  logic [W-1:0]  exp_l[$];
  int            pop_cyc[$];
  logic [W-1:0]  em, el;
  logic          watch_ready = 1'b0;
  logic          ready_dropped = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_word_assembler #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
    .din_ready(m_din_ready), .flush(flush), .dout(m_dout),
    .dout_valid(m_dout_valid), .dout_ready(dout_ready), .bit_count(m_bit_count)
  );

  serial_word_assembler #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
    .din_ready(l_din_ready), .flush(flush), .dout(l_dout),
    .dout_valid(l_dout_valid), .dout_ready(dout_ready), .bit_count(l_bit_count)
  );

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: every handshaked word is popped and compared
  always @(negedge clk) begin
    if (resetn && m_dout_valid && dout_ready) begin
      checks++;
      if (exp_m.size() == 0) begin
        errors++;
        $display("FAIL dout_msb unexpected word: got %0h expected none", m_dout);
      end else begin
        em = exp_m.pop_front();
        pop_cyc.push_back(cyc);
        if (m_dout !== em) begin
          errors++;
          $display("FAIL dout_msb: got %0h expected %0h", m_dout, em);
        end
      end
    end
    if (resetn && l_dout_valid && dout_ready) begin
      checks++;
      if (exp_l.size() == 0) begin
        errors++;
        $display("FAIL dout_lsb unexpected word: got %0h expected none", l_dout);
      end else begin
        el = exp_l.pop_front();
        if (l_dout !== el) begin
          errors++;
          $display("FAIL dout_lsb: got %0h expected %0h", l_dout, el);
        end
      end
    end
    if (watch_ready && !m_din_ready) ready_dropped = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    exp_m.push_back(w);
    exp_l.push_back(rev(w));
    for (int i = W - 1; i >= 0; i--) begin
      din_valid = 1'b1;
      din       = w[i];
      tick();
    end
    din_valid = 1'b0;
    din       = 1'b0;
  endtask

  task automatic send_bits(input int n, input logic b);
    for (int i = 0; i < n; i++) begin
      din_valid = 1'b1;
      din       = b;
      tick();
    end
    din_valid = 1'b0;
    din       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; din = 1'b0; din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b1;
    tick(); tick();
    chk("reset_dout_valid", m_dout_valid, 0);
    chk("reset_dout", m_dout, 0);
    chk("reset_bit_count", m_bit_count, 0);
    chk("reset_din_ready", m_din_ready, 1);
    resetn = 1'b1;
    tick();

    // basic assembly: B2 MSB-first, 4D LSB-first
    send_word(8'hB2);
    chk("basic_valid_after_last_bit", m_dout_valid, 1);
    chk("basic_dout", m_dout, 8'hB2);
    chk("order_dout_lsb", l_dout, 8'h4D);
    chk("basic_bit_count", m_bit_count, 0);
    tick();
    chk("basic_valid_one_cycle", m_dout_valid, 0);

    // backpressure: second word parks in HOLD
    dout_ready = 1'b0;
    send_word(8'hB2);
    send_word(8'hFF);
    chk("bp_din_ready_low", m_din_ready, 0);
    chk("bp_bit_count_full", m_bit_count, 8);
    chk("bp_dout_stable", m_dout, 8'hB2);
    tick();
    chk("bp_dout_still_stable", m_dout, 8'hB2);
    chk("bp_valid_held", m_dout_valid, 1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("bp_second_word", m_dout, 8'hFF);
    chk("bp_second_valid", m_dout_valid, 1);
    chk("bp_din_ready_back", m_din_ready, 1);
    chk("bp_bit_count_zero", m_bit_count, 0);
    dout_ready = 1'b1;
    tick();

    // flush in FILL drops the partial word and the coincident bit
    send_bits(5, 1'b1);
    chk("flush_pre_count", m_bit_count, 5);
    flush = 1'b1; din_valid = 1'b1; din = 1'b1;
    tick();
    flush = 1'b0; din_valid = 1'b0; din = 1'b0;
    chk("flush_bit_count", m_bit_count, 0);
    chk("flush_din_ready", m_din_ready, 1);
    send_word(8'h0F);
    tick();

    // flush in HOLD is ignored
    dout_ready = 1'b0;
    send_word(8'hA5);
    send_word(8'h3C);
    flush = 1'b1; din_valid = 1'b1; din = 1'b1;
    tick();
    flush = 1'b0; din_valid = 1'b0; din = 1'b0;
    chk("hold_flush_count", m_bit_count, 8);
    chk("hold_flush_din_ready", m_din_ready, 0);
    chk("hold_flush_dout", m_dout, 8'hA5);
    dout_ready = 1'b1;
    tick(); tick();

    // reset mid-word
    send_bits(6, 1'b1);
    chk("midword_count", m_bit_count, 6);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("midreset_count", m_bit_count, 0);
    chk("midreset_valid", m_dout_valid, 0);
    chk("midreset_dout", m_dout, 0);
    send_word(8'h96);
    tick();

    // streaming four words back-to-back
    pop_cyc.delete();
    watch_ready = 1'b1;
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h77);
    send_word(8'hE8);
    watch_ready = 1'b0;
    tick(); tick();
    chk("stream_din_ready_never_low", ready_dropped, 0);
    chk("stream_pulse_count", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("stream_spacing", pop_cyc[i] - pop_cyc[i-1], 8);
    end

    chk("scoreboard_msb_drained", exp_m.size(), 0);
    chk("scoreboard_lsb_drained", exp_l.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
